// File: rtl/processor_pkg.sv
// Shared encodings for the core-to-memory interface: memory-op codes,
// data-memory FSM states, default word width and the address range check.
package processor_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int BUS_ADDR_W = 16;

  localparam logic [1:0] MEM_IDLE = 2'b00;
  localparam logic [1:0] MEM_WR   = 2'b01;
  localparam logic [1:0] MEM_RD   = 2'b10;
  localparam logic [1:0] MEM_RSV  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_ADDR   = 3'd1,
    ST_RD_DATA   = 3'd2,
    ST_H_RD_ADDR = 3'd3,
    ST_H_RD_DATA = 3'd4
  } mem_state_e;

  // True when any address bit above the RAM's own index bits is set.
  function automatic logic addr_oor(input logic [BUS_ADDR_W-1:0] addr,
                                    input int unsigned            aw);
    return (addr >> aw) != '0;
  endfunction

endpackage

// File: rtl/sp_bram.sv
// Single-port RAM, read-first, registered output: 1-cycle read latency.
// Always ready; one access per cycle, no backpressure.
module sp_bram #(
  parameter int    DATA_W    = 16,
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Core data-memory stage: write in 1 edge, read data 2 edges after issue.
// No backpressure: ops seen while busy or from the non-owner are dropped and flagged.
module data_mem_ctrl
  import processor_pkg::*;
#(
  parameter int    DATA_W    = DATA_W_DEF,
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [15:0]       addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        mem_op,
  output logic [DATA_W-1:0] dram_out,
  output logic              rd_valid,
  output logic              busy,
  input  logic              cpu_halt,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [15:0]       host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              range_err,
  output logic              drop_err
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              rbad_q, rbad_d;
  logic [DATA_W-1:0] dram_out_q, dram_out_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic              host_ack_q, host_ack_d;
  logic              range_err_q, range_err_d;
  logic              drop_err_q, drop_err_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              core_oor;
  logic              host_oor;

  assign core_oor = addr_oor(addr_in, ADDR_W);
  assign host_oor = addr_oor(host_addr, ADDR_W);

  sp_bram #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk_i  (clock),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    raddr_d      = raddr_q;
    rbad_d       = rbad_q;
    dram_out_d   = dram_out_q;
    host_rdata_d = host_rdata_q;
    rd_valid_d   = 1'b0;
    host_ack_d   = 1'b0;
    range_err_d  = range_err_q;
    drop_err_d   = drop_err_q;
    ram_we       = 1'b0;
    ram_addr     = raddr_q;
    ram_wdata    = data_in;

    // Anything presented while a read is in flight is lost.
    if (state_q != ST_IDLE && (mem_op != MEM_IDLE || host_req)) begin
      drop_err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!cpu_halt) begin
          if (host_req) begin
            drop_err_d = 1'b1;
          end
          if (mem_op == MEM_WR) begin
            if (core_oor) begin
              range_err_d = 1'b1;
            end else begin
              ram_we    = 1'b1;
              ram_addr  = addr_in[ADDR_W-1:0];
              ram_wdata = data_in;
            end
          end else if (mem_op == MEM_RD) begin
            raddr_d = addr_in[ADDR_W-1:0];
            rbad_d  = core_oor;
            if (core_oor) begin
              range_err_d = 1'b1;
            end
            state_d = ST_RD_ADDR;
          end
        end else begin
          if (mem_op == MEM_WR || mem_op == MEM_RD) begin
            drop_err_d = 1'b1;
          end
          if (host_req && host_we) begin
            host_ack_d = 1'b1;
            if (host_oor) begin
              range_err_d = 1'b1;
            end else begin
              ram_we    = 1'b1;
              ram_addr  = host_addr[ADDR_W-1:0];
              ram_wdata = host_wdata;
            end
          end else if (host_req) begin
            raddr_d = host_addr[ADDR_W-1:0];
            rbad_d  = host_oor;
            if (host_oor) begin
              range_err_d = 1'b1;
            end
            state_d = ST_H_RD_ADDR;
          end
        end
      end
      ST_RD_ADDR:   state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        dram_out_d = rbad_q ? '0 : ram_rdata;
        rd_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_H_RD_ADDR: state_d = ST_H_RD_DATA;
      ST_H_RD_DATA: begin
        host_rdata_d = rbad_q ? '0 : ram_rdata;
        host_ack_d   = 1'b1;
        state_d      = ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      raddr_q      <= '0;
      rbad_q       <= 1'b0;
      dram_out_q   <= '0;
      host_rdata_q <= '0;
      rd_valid_q   <= 1'b0;
      host_ack_q   <= 1'b0;
      range_err_q  <= 1'b0;
      drop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      raddr_q      <= raddr_d;
      rbad_q       <= rbad_d;
      dram_out_q   <= dram_out_d;
      host_rdata_q <= host_rdata_d;
      rd_valid_q   <= rd_valid_d;
      host_ack_q   <= host_ack_d;
      range_err_q  <= range_err_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign dram_out   = dram_out_q;
  assign host_rdata = host_rdata_q;
  assign rd_valid   = rd_valid_q;
  assign host_ack   = host_ack_q;
  assign range_err  = range_err_q;
  assign drop_err   = drop_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
